game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 10000000; clk cycles per game tick (100 ms at 100 MHz); legal range 2..2^24.
REQ-002 The block SHALL have parameter DEATH_TICKS, default 20; game ticks spent in DYING before OVER; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit; the single system clock.
REQ-004 The block SHALL have port rst, input, 1 bit; asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit; debounced single-cycle start/pause pulse.
REQ-006 The block SHALL have port collide, input, 1 bit; collision flag from the play core, level.
REQ-007 The block SHALL have port score, input, 16 bits; current score from the play core.
REQ-008 The block SHALL have port tick_en, output, 1 bit; one-cycle game-step strobe to the play core.
REQ-009 The block SHALL have port core_rst_n, output, 1 bit; active-low restart to the play core.
REQ-010 The block SHALL have port state, output, 3 bits; current FSM state code.
REQ-011 The block SHALL have port high_score, output, 16 bits; best score since reset.

Function
REQ-012 The FSM SHALL have states IDLE=0, PLAY=1, DYING=2, OVER=3 and PAUSE=4; PAUSE exists only when the configuration macro is defined.
REQ-013 In IDLE, a start pulse SHALL move the FSM to PLAY.
REQ-014 In PLAY, collide=1 SHALL move the FSM to DYING; collide has priority over a start pulse arriving in the same cycle.
REQ-015 In DYING, the FSM SHALL go to OVER in the cycle after the DEATH_TICKS-th tick_en counted in DYING.
REQ-016 In OVER, a start pulse SHALL move the FSM to PLAY.
REQ-017 On every transition IDLE->PLAY or OVER->PLAY, core_rst_n SHALL be 0 for exactly the first PLAY cycle; it SHALL be 1 at all other times outside reset.
REQ-018 The tick divider SHALL be a counter 0..TICK_DIV-1 that advances only in PLAY and DYING and holds in all other states.
REQ-019 The tick divider SHALL be cleared to 0 on entry to PLAY from IDLE or OVER.
REQ-020 tick_en SHALL be 1 for one cycle when the divider equals TICK_DIV-1 while the FSM is in PLAY or DYING, and the divider SHALL then wrap to 0.
REQ-021 The first tick_en after entering PLAY SHALL occur TICK_DIV cycles after entry.
REQ-022 The death counter SHALL load DEATH_TICKS on entry to DYING and decrement on each tick_en while in DYING.
REQ-023 On entry to OVER, high_score SHALL be loaded with score if score > high_score (unsigned compare); otherwise high_score SHALL be unchanged.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 While rst=0, the block SHALL hold state=IDLE, tick_en=0, core_rst_n=0, high_score=0, and divider and death counter at 0.
REQ-026 Once rst is released, core_rst_n SHALL be 1 from the first clk edge, and the FSM SHALL remain in IDLE until start.
REQ-027 Asserting rst mid-game (any state) SHALL abort immediately to the reset values, with no tick_en glitch.

Configuration
REQ-028 When macro GAME_PAUSE_EN is defined, a start pulse without collide in PLAY SHALL go to PAUSE, and a start pulse in PAUSE SHALL return to PLAY.
REQ-029 When GAME_PAUSE_EN is defined, in PAUSE tick_en SHALL be 0 and the divider SHALL hold, so resuming continues the partial tick count.
REQ-030 When GAME_PAUSE_EN is defined, collide SHALL be ignored in PAUSE.
REQ-031 When GAME_PAUSE_EN is not defined, start SHALL be ignored in PLAY and code 4 SHALL never appear on state.

Structure
REQ-032 The state encoding constants, DEATH_TICKS default and TICK_DIV default SHALL live in shared package game_pkg, for reuse by the display and score logic.
REQ-033 The divider SHALL be a sub-module tick_gen (ports clk, rst, run, clear, tick); the FSM, death counter and high-score register SHALL be in game_sequencer.

Verification (TICK_DIV=4, DEATH_TICKS=3)
REQ-034 Bench SHALL check: reset released, no start for 50 cycles -> state=0, tick_en never 1, core_rst_n=1.
REQ-035 Bench SHALL check: start pulse in IDLE -> state=1 next cycle, core_rst_n=0 for one cycle, tick_en pulses at 4, 8, 12 cycles after entry.
REQ-036 Bench SHALL check: collide=1 with start=1 in the same cycle in PLAY -> state=2, then state=3 one cycle after the 3rd tick_en, with score=37 over high_score=0 -> high_score=37.
REQ-037 Bench SHALL check: in OVER, score=20, start -> PLAY with a core_rst_n pulse and divider restarting at 0; a later death -> high_score stays 37.
REQ-038 Bench SHALL check, with GAME_PAUSE_EN defined: start 2 cycles after a tick in PLAY -> state=4, no tick for 100 cycles, collide ignored; start -> state=1 and next tick 2 cycles later.
REQ-039 Bench SHALL check: rst asserted in DYING -> immediately state=0, tick_en=0, high_score=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: FSM state codes and timing defaults, also used by display/score logic.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_DYING = 3'd2,
    ST_OVER  = 3'd3,
    ST_PAUSE = 3'd4
  } game_state_t;

  localparam int TICK_DIV_DEFAULT    = 10000000;
  localparam int DEATH_TICKS_DEFAULT = 20;

  function automatic logic is_running(game_state_t s);
    return (s == ST_PLAY) || (s == ST_DYING);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Game tick divider: counts 0..TICK_DIV-1 while run is high, emits a registered one-cycle tick on wrap.
module tick_gen
  import game_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_reg;
  logic             tick_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      if (clear) begin
        div_reg <= '0;
      end else if (run) begin
        if (div_reg == DIV_MAX) begin
          div_reg  <= '0;
          tick_reg <= 1'b1;
        end else begin
          div_reg <= div_reg + 1'b1;
        end
      end
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/game_sequencer.sv
// Game flow FSM (IDLE/PLAY/DYING/OVER), death timer and high-score register.
// Optional pause state enabled by defining GAME_PAUSE_EN.
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEFAULT,
  parameter int DEATH_TICKS = DEATH_TICKS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        collide,
  input  logic [15:0] score,
  output logic        tick_en,
  output logic        core_rst_n,
  output logic [2:0]  state,
  output logic [15:0] high_score
);

  game_state_t state_reg;
  logic [7:0]  death_cnt_reg;
  logic [15:0] high_score_reg;
  logic        core_rst_n_reg;
  logic        tick_w;
  logic        restart;
  logic        pause_req;
  logic        run;

  always_comb begin
    restart = ((state_reg == ST_IDLE) || (state_reg == ST_OVER)) && start;
`ifdef GAME_PAUSE_EN
    pause_req = (state_reg == ST_PLAY) && start && !collide;
`else
    pause_req = 1'b0;
`endif
    // The cycle that requests pause does not advance the divider, so a resume
    // continues exactly where counting stopped.
    run = is_running(state_reg) && !pause_req;
  end

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clear(restart),
    .tick (tick_w)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      death_cnt_reg  <= 8'd0;
      high_score_reg <= 16'd0;
      core_rst_n_reg <= 1'b0;
    end else begin
      core_rst_n_reg <= !restart;
      case (state_reg)
        ST_IDLE, ST_OVER: begin
          if (start) state_reg <= ST_PLAY;
        end
        ST_PLAY: begin
          if (collide) begin
            state_reg     <= ST_DYING;
            death_cnt_reg <= 8'(DEATH_TICKS);
          end else if (pause_req) begin
            state_reg <= ST_PAUSE;
          end
        end
        ST_DYING: begin
          if (tick_w) begin
            death_cnt_reg <= death_cnt_reg - 8'd1;
            if (death_cnt_reg == 8'd1) begin
              state_reg <= ST_OVER;
              if (score > high_score_reg) high_score_reg <= score;
            end
          end
        end
`ifdef GAME_PAUSE_EN
        ST_PAUSE: begin
          if (start) state_reg <= ST_PLAY;
        end
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign tick_en    = tick_w;
  assign core_rst_n = core_rst_n_reg;
  assign state      = state_reg;
  assign high_score = high_score_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer (TICK_DIV=4, DEATH_TICKS=3): vector table, directed corners, random vs model.
module tb_game_sequencer;

  localparam int TD = 4;
  localparam int DT = 3;
`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        collide = 1'b0;
  logic [15:0] score = 16'd0;
  logic        tick_en;
  logic        core_rst_n;
  logic [2:0]  state;
  logic [15:0] high_score;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  game_sequencer #(
    .TICK_DIV   (TD),
    .DEATH_TICKS(DT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .collide   (collide),
    .score     (score),
    .tick_en   (tick_en),
    .core_rst_n(core_rst_n),
    .state     (state),
    .high_score(high_score)
  );

  // Reference model: game phase as an int, ticks from counted play cycles.
  int          m_state;
  int          m_elapsed;
  int          m_deaths;
  bit          m_tick;
  bit          m_crn;
  logic [15:0] m_hs;

  task automatic model_reset();
    m_state = 0; m_elapsed = 0; m_deaths = 0;
    m_tick = 1'b0; m_crn = 1'b0; m_hs = 16'd0;
  endtask

  function automatic void model_step(bit s, bit c, logic [15:0] sc);
    bit entering = ((m_state == 0) || (m_state == 3)) && s;
    bit to_pause = PAUSE_EN && (m_state == 1) && s && !c;
    bit counts   = ((m_state == 1) && !to_pause) || (m_state == 2);
    int nxt      = m_state;
    bit ntick    = 1'b0;
    case (m_state)
      0, 3, 4: if (s) nxt = 1;
      1: if (c) nxt = 2; else if (to_pause) nxt = 4;
      2: if (m_tick) begin
        m_deaths++;
        if (m_deaths == DT) nxt = 3;
      end
      default: nxt = 0;
    endcase
    if (nxt == 2 && m_state != 2) m_deaths = 0;
    if (nxt == 3 && m_state == 2 && sc > m_hs) m_hs = sc;
    if (entering) m_elapsed = 0;
    else if (counts) begin
      m_elapsed++;
      if (m_elapsed == TD) begin
        ntick = 1'b1;
        m_elapsed = 0;
      end
    end
    m_tick  = ntick;
    m_crn   = !entering;
    m_state = nxt;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_cycle(bit s, bit c, logic [15:0] sc);
    start = s; collide = c; score = sc;
    model_step(s, c, sc);
    @(posedge clk);
    #1;
    check("model", {11'd0, state, tick_en, core_rst_n, high_score},
          {11'd0, m_state[2:0], m_tick, m_crn, m_hs});
  endtask

  typedef struct {
    bit          s;
    bit          c;
    logic [15:0] sc;
    logic [2:0]  st;
    bit          tk;
    bit          crn;
    logic [15:0] hs;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit s, bit c, logic [15:0] sc, logic [2:0] st, bit tk, bit crn,
                              logic [15:0] hs);
    vec_t v;
    v.s = s; v.c = c; v.sc = sc; v.st = st; v.tk = tk; v.crn = crn; v.hs = hs;
    vecs.push_back(v);
  endfunction

  initial begin
    bit saw_tick;

    // Row k: inputs sampled at edge k, expected outputs for cycle k after entry.
    add(1, 0, 37, 3'd1, 0, 0, 0);
    for (int k = 1; k <= 12; k++) add(0, 0, 37, 3'd1, (k % 4) == 0, 1, 0);
    add(1, 1, 37, 3'd2, 0, 1, 0);
    for (int k = 14; k <= 24; k++) add(0, 0, 37, 3'd2, (k % 4) == 0, 1, 0);
    add(0, 0, 37, 3'd3, 0, 1, 37);
    add(1, 0, 20, 3'd1, 0, 0, 37);
    for (int k = 27; k <= 30; k++) add(0, 0, 20, 3'd1, k == 30, 1, 37);
    add(0, 1, 20, 3'd2, 0, 1, 37);
    for (int k = 32; k <= 42; k++) add(0, 0, 20, 3'd2, ((k - 30) % 4) == 0, 1, 37);
    add(0, 0, 20, 3'd3, 0, 1, 37);

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", state, 0);
    check("reset_tick", tick_en, 0);
    check("reset_crn", core_rst_n, 0);
    check("reset_hs", high_score, 0);
    rst = 1'b1;

    saw_tick = 1'b0;
    repeat (50) begin
      do_cycle(0, 0, 0);
      saw_tick |= tick_en;
    end
    check("idle_state", state, 0);
    check("idle_no_tick", saw_tick, 0);
    check("idle_crn", core_rst_n, 1);
    $display("idle: 50 cycles state=%0d crn=%0b", state, core_rst_n);

    foreach (vecs[i]) begin
      do_cycle(vecs[i].s, vecs[i].c, vecs[i].sc);
      check("vec_state", state, vecs[i].st);
      check("vec_tick", tick_en, vecs[i].tk);
      check("vec_crn", core_rst_n, vecs[i].crn);
      check("vec_hs", high_score, vecs[i].hs);
      $display("vec %0d: start=%0b collide=%0b score=%0d -> state=%0d tick=%0b crn=%0b hs=%0d",
               i, vecs[i].s, vecs[i].c, vecs[i].sc, state, tick_en, core_rst_n, high_score);
    end

    // Restart from OVER, then start 2 cycles after a tick.
    do_cycle(1, 0, 20);
    check("restart_crn", core_rst_n, 0);
    repeat (4) do_cycle(0, 0, 20);
    check("restart_tick", tick_en, 1);
    repeat (2) do_cycle(0, 0, 20);
    do_cycle(1, 0, 20);
`ifdef GAME_PAUSE_EN
    check("pause_enter", state, 4);
    saw_tick = 1'b0;
    repeat (100) begin
      do_cycle(0, 1'($urandom_range(0, 1)), 20);
      saw_tick |= tick_en;
    end
    check("pause_state", state, 4);
    check("pause_no_tick", saw_tick, 0);
    do_cycle(1, 0, 20);
    check("resume_state", state, 1);
    check("resume_crn", core_rst_n, 1);
    do_cycle(0, 0, 20);
    check("resume_tick_early", tick_en, 0);
    do_cycle(0, 0, 20);
    check("resume_tick", tick_en, 1);
    $display("pause: resumed, tick after 2 cycles=%0b", tick_en);
`else
    check("start_ignored", state, 1);
    do_cycle(0, 0, 20);
    check("play_tick", tick_en, 1);
    $display("no-pause: start in PLAY ignored, state=%0d", state);
`endif

    // Asynchronous reset in DYING.
    do_cycle(0, 1, 20);
    check("dying", state, 2);
    do_cycle(0, 0, 20);
    #3 rst = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_tick", tick_en, 0);
    check("arst_hs", high_score, 0);
    check("arst_crn", core_rst_n, 0);
    $display("async reset in DYING: state=%0d hs=%0d", state, high_score);
    model_reset();
    start = 1'b0; collide = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("arst_hold_state", state, 0);
    rst = 1'b1;

    repeat (4000) do_cycle($urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0, 16'($urandom));
    $display("random: 4000 cycles done, hs=%0d", high_score);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
